// File: rtl/branch_predictor_if.sv
// ============================================================================
// Module      : branch_predictor_if
// Description : IF/ID-side signal bundle between the pipeline and the
//               branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_if;
    logic [31:0] IF_PC;
    logic [5:0]  IF_op;
    logic        IF_ID_stall;
    logic        IF_ID_flush;
    logic        ID_isBranch;
    logic        ID_taken;
    logic [31:0] ID_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ID_pred_taken;
    logic        mispredict;
    logic [31:0] redirect_PC;
    logic [15:0] miss_count;

    modport master (
        output IF_PC, IF_op, IF_ID_stall, IF_ID_flush, ID_isBranch, ID_taken, ID_target,
        input  pred_taken, pred_target, ID_pred_taken, mispredict, redirect_PC, miss_count
    );

    modport slave (
        input  IF_PC, IF_op, IF_ID_stall, IF_ID_flush, ID_isBranch, ID_taken, ID_target,
        output pred_taken, pred_target, ID_pred_taken, mispredict, redirect_PC, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : 16-entry direct-mapped BTB with 2-bit counters, IF lookup,
//               ID-stage resolution check, redirect and miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor (
    input  wire logic          clock,
    input  wire logic          reset,
    branch_predictor_if.slave  bus
);

    localparam int         c_entries   = 16;
    localparam logic [1:0] c_ctr_reset = 2'b01;
    localparam logic [1:0] c_ctr_alloc = 2'b10;
    localparam logic [1:0] c_ctr_max   = 2'b11;
    localparam logic [1:0] c_ctr_min   = 2'b00;
    localparam logic [15:0] c_miss_max = 16'hFFFF;

    logic [c_entries-1:0] valid_q, valid_d;
    logic [25:0]          tag_q    [c_entries];
    logic [25:0]          tag_d    [c_entries];
    logic [31:0]          target_q [c_entries];
    logic [31:0]          target_d [c_entries];
    logic [1:0]           ctr_q    [c_entries];
    logic [1:0]           ctr_d    [c_entries];

    logic        id_valid_q, id_valid_d;
    logic        id_pred_taken_q, id_pred_taken_d;
    logic [31:0] id_pred_target_q, id_pred_target_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic [3:0]  w_if_idx;
    logic        w_if_branch;
    logic        w_if_hit;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;
    logic        w_mispredict;
    logic [3:0]  w_upd_idx;
    logic        w_upd_hit;
    logic        w_update;

    // IF-side lookup; outputs are forced quiet while reset is held
    always_comb begin
        w_if_idx = bus.IF_PC[5:2];
        case (bus.IF_op)
            6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: w_if_branch = 1'b1;
            default:                                               w_if_branch = 1'b0;
        endcase
        w_if_hit      = valid_q[w_if_idx] && (tag_q[w_if_idx] == bus.IF_PC[31:6]);
        w_pred_taken  = !reset && w_if_branch && w_if_hit && ctr_q[w_if_idx][1];
        w_pred_target = w_if_hit ? target_q[w_if_idx] : (bus.IF_PC + 32'd4);
    end

    always_comb begin
        w_mispredict = !reset && bus.ID_isBranch && id_valid_q &&
                       ((id_pred_taken_q != bus.ID_taken) ||
                        (bus.ID_taken && (id_pred_target_q != bus.ID_target)));
        w_upd_idx    = id_pc_q[5:2];
        w_upd_hit    = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == id_pc_q[31:6]);
        w_update     = bus.ID_isBranch && id_valid_q && !bus.IF_ID_stall;
    end

    assign bus.pred_taken    = w_pred_taken;
    assign bus.pred_target   = w_pred_target;
    assign bus.ID_pred_taken = id_pred_taken_q;
    assign bus.mispredict    = w_mispredict;
    assign bus.redirect_PC   = reset ? 32'd4 :
                               (bus.ID_taken ? bus.ID_target : (id_pc_q + 32'd4));
    assign bus.miss_count    = miss_count_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (w_update) begin
            if (w_upd_hit) begin
                if (bus.ID_taken) begin
                    if (ctr_q[w_upd_idx] != c_ctr_max) ctr_d[w_upd_idx] = ctr_q[w_upd_idx] + 2'd1;
                    target_d[w_upd_idx] = bus.ID_target;
                end else if (ctr_q[w_upd_idx] != c_ctr_min) begin
                    ctr_d[w_upd_idx] = ctr_q[w_upd_idx] - 2'd1;
                end
            end else if (bus.ID_taken) begin
                valid_d[w_upd_idx]  = 1'b1;
                tag_d[w_upd_idx]    = id_pc_q[31:6];
                target_d[w_upd_idx] = bus.ID_target;
                ctr_d[w_upd_idx]    = c_ctr_alloc;
            end
        end
    end

    // Flush wins over stall; a stalled register keeps its contents
    always_comb begin
        id_valid_d       = id_valid_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        id_pc_d          = id_pc_q;
        if (bus.IF_ID_flush) begin
            id_valid_d      = 1'b0;
            id_pred_taken_d = 1'b0;
        end else if (!bus.IF_ID_stall) begin
            id_valid_d       = 1'b1;
            id_pred_taken_d  = w_pred_taken;
            id_pred_target_d = w_pred_target;
            id_pc_d          = bus.IF_PC;
        end
    end

    always_comb begin
        miss_count_d = miss_count_q;
        if (w_mispredict && !bus.IF_ID_stall && (miss_count_q != c_miss_max))
            miss_count_d = miss_count_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < c_entries; i++) ctr_q[i] <= c_ctr_reset;
            id_valid_q       <= 1'b0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= 32'd0;
            id_pc_q          <= 32'd0;
            miss_count_q     <= 16'd0;
        end else begin
            valid_q          <= valid_d;
            ctr_q            <= ctr_d;
            id_valid_q       <= id_valid_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            id_pc_q          <= id_pc_d;
            miss_count_q     <= miss_count_d;
        end
    end

    // Tag and target need no reset: an entry is only trusted once valid
    always_ff @(posedge clock) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed and randomized bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] NOP = 6'b000000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    branch_predictor_if bus ();
    branch_predictor dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_id_valid;
    bit          m_id_pred;
    logic [31:0] m_id_tgt;
    logic [31:0] m_id_pc;
    int          m_miss;

    logic        exp_pt, exp_idp, exp_mis;
    logic [31:0] exp_ptgt, exp_redir;
    logic [15:0] exp_miss;

    logic [5:0] op_pool [7] = '{6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b000000, 6'b100011};

    function automatic bit is_branch(input logic [5:0] op);
        return op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001};
    endfunction

    function automatic bit lookup_hit(input logic [31:0] pc);
        int i = int'(pc[5:2]);
        return m_valid[i] && (m_tag[i] == pc[31:6]);
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [5:0] op, input logic stall,
                         input logic flush, input logic isb, input logic taken, input logic [31:0] tgt);
        bus.IF_PC = pc; bus.IF_op = op; bus.IF_ID_stall = stall; bus.IF_ID_flush = flush;
        bus.ID_isBranch = isb; bus.ID_taken = taken; bus.ID_target = tgt;
    endtask

    task automatic model_outputs();
        int i = int'(bus.IF_PC[5:2]);
        bit hit = lookup_hit(bus.IF_PC);
        exp_pt    = !reset && is_branch(bus.IF_op) && hit && (m_ctr[i] >= 2);
        exp_ptgt  = hit ? m_tgt[i] : bus.IF_PC + 32'd4;
        exp_idp   = m_id_pred;
        exp_mis   = !reset && bus.ID_isBranch && m_id_valid &&
                    ((m_id_pred != bus.ID_taken) || (bus.ID_taken && m_id_tgt != bus.ID_target));
        exp_redir = reset ? 32'd4 : (bus.ID_taken ? bus.ID_target : m_id_pc + 32'd4);
        exp_miss  = 16'(m_miss);
    endtask

    // Advance one clock, updating the model from the inputs present before the edge
    task automatic tick();
        bit mis;
        model_outputs();
        mis = exp_mis;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
            m_id_valid = 0; m_id_pred = 0; m_id_tgt = 0; m_id_pc = 0; m_miss = 0;
        end else begin
            if (bus.ID_isBranch && m_id_valid && !bus.IF_ID_stall) begin
                int u = int'(m_id_pc[5:2]);
                if (lookup_hit(m_id_pc)) begin
                    if (bus.ID_taken) begin
                        m_ctr[u] = (m_ctr[u] + 1 > 3) ? 3 : m_ctr[u] + 1;
                        m_tgt[u] = bus.ID_target;
                    end else begin
                        m_ctr[u] = (m_ctr[u] - 1 < 0) ? 0 : m_ctr[u] - 1;
                    end
                end else if (bus.ID_taken) begin
                    m_valid[u] = 1; m_tag[u] = m_id_pc[31:6]; m_tgt[u] = bus.ID_target; m_ctr[u] = 2;
                end
            end
            if (mis && !bus.IF_ID_stall && m_miss < 65535) m_miss++;
            if (bus.IF_ID_flush) begin
                m_id_valid = 0; m_id_pred = 0;
            end else if (!bus.IF_ID_stall) begin
                m_id_valid = 1; m_id_pred = exp_pt; m_id_tgt = exp_ptgt; m_id_pc = bus.IF_PC;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h40, BEQ, 0, 0, 1, 1, 32'h1234_0000);
        #2;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got %0b want 0", bus.pred_taken); end
        checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rst_mispredict got %0b want 0", bus.mispredict); end
        checks++; if (bus.redirect_PC !== 32'h4) begin errors++; $display("FAIL rst_redirect got %h want 00000004", bus.redirect_PC); end
        tick(); tick();
        reset = 1'b0;
        drive(32'h0, NOP, 0, 0, 1, 1, 32'h1234_0000);
        #2;
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL rst_miss_count got %0d want 0", bus.miss_count); end
        checks++; if (bus.ID_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_id_pred got %0b want 0", bus.ID_pred_taken); end
        checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rst_id_invalid_mis got %0b want 0", bus.mispredict); end
        tick();
    endtask

    task automatic test_allocate();
        drive(32'h40, BEQ, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_pred got %0b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h44) begin errors++; $display("FAIL alloc_ptgt got %h want 00000044", bus.pred_target); end
        tick();
        drive(32'h44, NOP, 0, 1, 1, 1, 32'h80); #2;
        checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mis got %0b want 1", bus.mispredict); end
        checks++; if (bus.redirect_PC !== 32'h80) begin errors++; $display("FAIL alloc_redirect got %h want 00000080", bus.redirect_PC); end
        tick();
        drive(32'h48, NOP, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.miss_count !== 16'd1) begin errors++; $display("FAIL alloc_miss_count got %0d want 1", bus.miss_count); end
        tick();
    endtask

    task automatic test_strengthen();
        drive(32'h40, BEQ, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL str_pred got %0b want 1", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h80) begin errors++; $display("FAIL str_ptgt got %h want 00000080", bus.pred_target); end
        tick();
        drive(32'h40, BEQ, 0, 0, 1, 1, 32'h80); #2;
        checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL str_mis1 got %0b want 0", bus.mispredict); end
        checks++; if (bus.ID_pred_taken !== 1'b1) begin errors++; $display("FAIL str_id_pred got %0b want 1", bus.ID_pred_taken); end
        tick();
        drive(32'h44, NOP, 0, 0, 1, 1, 32'h80); #2;
        checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL str_mis2 got %0b want 0", bus.mispredict); end
        tick();
    endtask

    task automatic test_weaken();
        drive(32'h40, BEQ, 0, 0, 0, 0, 0); #2; tick();
        drive(32'h40, BEQ, 0, 0, 1, 0, 0); #2;
        checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL wk_mis1 got %0b want 1", bus.mispredict); end
        checks++; if (bus.redirect_PC !== 32'h44) begin errors++; $display("FAIL wk_redirect got %h want 00000044", bus.redirect_PC); end
        tick();
        drive(32'h44, NOP, 0, 0, 1, 0, 0); #2;
        checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL wk_mis2 got %0b want 1", bus.mispredict); end
        tick();
        drive(32'h40, BEQ, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL wk_pred got %0b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h80) begin errors++; $display("FAIL wk_ptgt got %h want 00000080", bus.pred_target); end
        checks++; if (bus.miss_count !== 16'd3) begin errors++; $display("FAIL wk_miss_count got %0d want 3", bus.miss_count); end
        tick();
    endtask

    task automatic test_alias();
        drive(32'h440, BNE, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_pred got %0b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h444) begin errors++; $display("FAIL alias_ptgt got %h want 00000444", bus.pred_target); end
        tick();
        drive(32'h444, NOP, 0, 0, 1, 1, 32'h500); #2;
        checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alias_mis got %0b want 1", bus.mispredict); end
        checks++; if (bus.redirect_PC !== 32'h500) begin errors++; $display("FAIL alias_redirect got %h want 00000500", bus.redirect_PC); end
        tick();
        drive(32'h440, BNE, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred got %0b want 1", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h500) begin errors++; $display("FAIL alias_new_ptgt got %h want 00000500", bus.pred_target); end
        tick();
        drive(32'h40, BEQ, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_pred got %0b want 0", bus.pred_taken); end
        checks++; if (bus.pred_target !== 32'h44) begin errors++; $display("FAIL alias_old_ptgt got %h want 00000044", bus.pred_target); end
        tick();
    endtask

    task automatic test_stall_flush();
        drive(32'h440, BNE, 0, 0, 0, 0, 0); #2; tick();
        for (int c = 0; c < 3; c++) begin
            drive(32'h444, NOP, 1, 0, 1, 0, 0); #2;
            checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL stall_mis[%0d] got %0b want 1", c, bus.mispredict); end
            checks++; if (bus.miss_count !== 16'd4) begin errors++; $display("FAIL stall_count[%0d] got %0d want 4", c, bus.miss_count); end
            tick();
        end
        drive(32'h444, NOP, 0, 1, 1, 0, 0); #2;
        checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL stall_release_mis got %0b want 1", bus.mispredict); end
        tick();
        drive(32'h440, BNE, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.miss_count !== 16'd5) begin errors++; $display("FAIL stall_once_count got %0d want 5", bus.miss_count); end
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL stall_weak_pred got %0b want 0", bus.pred_taken); end
        tick();
        drive(32'h444, NOP, 0, 1, 1, 1, 32'h500); #2; tick();
        drive(32'h440, BNE, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL stall_single_update got %0b want 1", bus.pred_taken); end
        tick();
        drive(32'h444, NOP, 1, 1, 0, 0, 0); #2; tick();
        drive(32'h448, NOP, 1, 0, 1, 1, 32'h600); #2;
        checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL flush_stall_mis got %0b want 0", bus.mispredict); end
        checks++; if (bus.ID_pred_taken !== 1'b0) begin errors++; $display("FAIL flush_stall_id_pred got %0b want 0", bus.ID_pred_taken); end
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1; drive(0, NOP, 0, 0, 0, 0, 0); tick(); tick(); reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, tgt;
            pc  = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            case ($urandom_range(0, 3))
                0: tgt = 32'h1000; 1: tgt = 32'h2000; 2: tgt = pc + 32'd4; default: tgt = $urandom;
            endcase
            reset = ($urandom_range(0, 99) < 2);
            drive(pc, op_pool[$urandom_range(0, 6)], ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt);
            #2;
            model_outputs();
            checks++; if (bus.pred_taken !== exp_pt) begin errors++; $display("FAIL rnd_pred[%0d] got %0b want %0b", n, bus.pred_taken, exp_pt); end
            checks++; if (!reset && bus.pred_target !== exp_ptgt) begin errors++; $display("FAIL rnd_ptgt[%0d] got %h want %h", n, bus.pred_target, exp_ptgt); end
            checks++; if (bus.ID_pred_taken !== exp_idp) begin errors++; $display("FAIL rnd_id_pred[%0d] got %0b want %0b", n, bus.ID_pred_taken, exp_idp); end
            checks++; if (bus.mispredict !== exp_mis) begin errors++; $display("FAIL rnd_mis[%0d] got %0b want %0b", n, bus.mispredict, exp_mis); end
            checks++; if (bus.redirect_PC !== exp_redir) begin errors++; $display("FAIL rnd_redirect[%0d] got %h want %h", n, bus.redirect_PC, exp_redir); end
            checks++; if (bus.miss_count !== exp_miss) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.miss_count, exp_miss); end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        drive(32'h100, NOP, 0, 0, 0, 0, 0); #2; tick();
        for (int n = 0; n < 65540; n++) begin
            drive(32'h100, NOP, 0, 0, 1, 1, 32'hDEAD_0000);
            tick();
        end
        #2;
        model_outputs();
        checks++; if (bus.miss_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h want ffff", bus.miss_count); end
        checks++; if (bus.mispredict !== exp_mis) begin errors++; $display("FAIL sat_mis got %0b want %0b", bus.mispredict, exp_mis); end
        tick();
        #2;
        checks++; if (bus.miss_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", bus.miss_count); end
    endtask

    task automatic test_reset_clears();
        reset = 1'b1; drive(32'h40, BEQ, 0, 0, 1, 1, 32'h80); tick(); reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] pc;
            pc = {24'd0, 2'(i / 16), 4'(i % 16), 2'b00};
            drive(pc, BEQ, 0, 0, 0, 0, 0); #2;
            checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL clr_pred[%0d] got %0b want 0", i, bus.pred_taken); end
            checks++; if (bus.pred_target !== pc + 32'd4) begin errors++; $display("FAIL clr_ptgt[%0d] got %h want %h", i, bus.pred_target, pc + 32'd4); end
            checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL clr_count[%0d] got %0d want 0", i, bus.miss_count); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; end
        m_id_valid = 0; m_id_pred = 0; m_id_tgt = 0; m_id_pc = 0; m_miss = 0;
        test_reset();
        test_allocate();
        test_strengthen();
        test_weaken();
        test_alias();
        test_stall_flush();
        test_random();
        test_saturate();
        test_reset_clears();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports `clock` and `reset`.
REQ-002 `clock`  in  1  rising-edge clock shared with the IF/ID pipeline registers.
REQ-003 `reset`  in  1  synchronous active-high reset.
REQ-004 `IF_PC`  in  32  PC of the instruction being fetched.
REQ-005 `IF_op`  in  6  opcode field of the fetched instruction.
REQ-006 `IF_ID_stall`  in  1  holds the IF/ID stage; prediction register keeps its value.
REQ-007 `IF_ID_flush`  in  1  squashes the IF instruction; the ID-side prediction becomes invalid.
REQ-008 `ID_isBranch`  in  1  ID holds a conditional branch (Beq/Bne/Bgez/Bgtz/Blez/Bltz/Bgezal/Bltzal).
REQ-009 `ID_taken`  in  1  resolved direction from the ID branch test (1 = taken).
REQ-010 `ID_target`  in  32  resolved target, PC+4+(sign-extended offset<<2).
REQ-011 `pred_taken`  out  1  IF prediction; the PC mux selects `pred_target` when 1.
REQ-012 `pred_target`  out  32  predicted target for the IF instruction.
REQ-013 `ID_pred_taken`  out  1  prediction registered alongside the ID instruction.
REQ-014 `mispredict`  out  1  ID-stage redirect request; also drives the IF flush.
REQ-015 `redirect_PC`  out  32  correct next PC when `mispredict`=1.
REQ-016 `miss_count`  out  16  saturating count of mispredictions.

Function
REQ-017 Branch detect: IF_branch = `IF_op` in {000100, 000101, 000110, 000111, 000001}.
REQ-018 Table: 16 entries, direct-mapped, index `IF_PC`[5:2]; each entry holds valid, tag PC[31:6], target[31:0] and a 2-bit counter.
REQ-019 Lookup: combinational; hit = valid && tag match; `pred_taken` = IF_branch && hit && counter[1]; `pred_target` = entry target when hit, else `IF_PC`+4.
REQ-020 ID register: captures `pred_taken`, `pred_target` and `IF_PC` when neither stall nor flush is asserted.
  - On stall, the register holds its value.
  - On flush (flush has priority over stall), it loads pred=0, valid=0.
REQ-021 Check: mispredict = `ID_isBranch` && ID_valid && (`ID_pred_taken` != `ID_taken` || (`ID_taken` && ID_pred_target != `ID_target`)); `mispredict` is combinational, with 0-cycle latency in ID.
REQ-022 Redirect: `redirect_PC` = `ID_taken` ? `ID_target` : ID_PC+4; the adder wraps modulo 2^32.
REQ-023 Update: on a rising edge with `ID_isBranch` && ID_valid && !`IF_ID_stall`, the entry at ID_PC[5:2] is written.
  - Hit, taken: counter saturates upward (11 stays 11) and target is rewritten.
  - Hit, not taken: counter saturates downward (00 stays 00).
  - Miss, taken: allocate with valid=1, tag, target, counter=10 (weakly taken), replacing any resident entry.
  - Miss, not taken: no write.
REQ-024 Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; transitions follow REQ-023 only.
REQ-025 Same-index read and write in one cycle: the IF lookup sees the pre-update entry; the new value is visible next cycle.
REQ-026 Update is suppressed while `IF_ID_stall`=1, so a held branch is updated exactly once.
REQ-027 `miss_count` increments by 1 on each cycle with `mispredict`=1 && !`IF_ID_stall` and saturates at 16'hFFFF.

Reset
REQ-028 A synchronous reset SHALL clear:
  - all valid bits to 0 and all counters to 01;
  - the ID register (pred=0, valid=0, target=0, PC=0);
  - `miss_count` to 0.
REQ-029 During reset, `pred_taken`=0, `mispredict`=0 and `redirect_PC`=0+4; reset asserted mid-update discards the update.

Verification
REQ-030 After reset, fetch beq at 0x0000_0040 -> `pred_taken`=0, `pred_target`=0x44; resolve taken to 0x0000_0080 -> `mispredict`=1, `redirect_PC`=0x80, entry 0 allocated with counter=10, `miss_count`=1.
REQ-031 Refetch the same beq -> `pred_taken`=1, `pred_target`=0x80; resolve taken -> `mispredict`=0 and counter=11; resolve taken again -> counter stays 11.
REQ-032 From counter=11, resolve not taken twice -> counter 10 then 01, `mispredict`=1 both times; the next fetch predicts `pred_taken`=0.
REQ-033 Alias: bne at 0x0000_0440 (same index, different tag) -> lookup miss, `pred_taken`=0; resolve taken -> entry replaced with the new tag.
REQ-034 Stall for 3 cycles with a mispredicting branch in ID -> single counter update, `miss_count` +1; flush in the same cycle as stall -> ID_valid=0, `mispredict`=0.
REQ-035 Force 65536 mispredictions -> `miss_count` holds 16'hFFFF; assert reset -> `miss_count`=0 and all lookups miss.
